// File: rtl/mult_sequence_ctrl_if.sv
// Handshake bundle between the multiplier sequence controller and its stages.
// master: controller side; slave: operand source plus stage side.
interface mult_sequence_ctrl_if #(
    parameter int OP_WIDTH = 8
) ();
    logic [OP_WIDTH-1:0]   operand_in;
    logic                  load_a;
    logic                  load_b;
    logic                  start;
    logic                  mult_done;
    logic [2*OP_WIDTH-1:0] mult_product;
    logic                  sm_ready;
    logic                  bcd_ready;
    logic                  mult_start;
    logic [OP_WIDTH-1:0]   mult_a;
    logic [OP_WIDTH-1:0]   mult_b;
    logic                  sm_valid;
    logic [2*OP_WIDTH-1:0] sm_data;
    logic                  bcd_valid;
    logic                  done;
    logic                  busy;
    logic                  error;
    logic [2:0]            state_dbg;

    modport master (
        input  operand_in, load_a, load_b, start,
        input  mult_done, mult_product, sm_ready, bcd_ready,
        output mult_start, mult_a, mult_b, sm_valid, sm_data,
        output bcd_valid, done, busy, error, state_dbg
    );

    modport slave (
        output operand_in, load_a, load_b, start,
        output mult_done, mult_product, sm_ready, bcd_ready,
        input  mult_start, mult_a, mult_b, sm_valid, sm_data,
        input  bcd_valid, done, busy, error, state_dbg
    );
endinterface

// File: rtl/mult_sequence_ctrl.sv
// Sequence controller: operand capture, multiply, sign-magnitude, BCD, done.
// Ports: clk, rst (sync, active-high), bus (mult_sequence_ctrl_if.master).
module mult_sequence_ctrl #(
    parameter int OP_WIDTH       = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    mult_sequence_ctrl_if.master bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // Last wait cycle: a ready still low here means the stage is dead.
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MULT = 3'd1,
        SIGN = 3'd2,
        BCD  = 3'd3,
        ERR  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  a_loaded_q, a_loaded_d;
    logic                  b_loaded_q, b_loaded_d;
    logic [OP_WIDTH-1:0]   mult_a_q, mult_a_d;
    logic [OP_WIDTH-1:0]   mult_b_q, mult_b_d;
    logic [2*OP_WIDTH-1:0] sm_data_q, sm_data_d;
    logic                  mult_start_q, mult_start_d;
    logic                  sm_valid_q, sm_valid_d;
    logic                  bcd_valid_q, bcd_valid_d;
    logic                  done_q, done_d;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        a_loaded_d   = a_loaded_q;
        b_loaded_d   = b_loaded_q;
        mult_a_d     = mult_a_q;
        mult_b_d     = mult_b_q;
        sm_data_d    = sm_data_q;
        mult_start_d = 1'b0;
        sm_valid_d   = 1'b0;
        bcd_valid_d  = 1'b0;
        done_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Launch uses registered flags, so a start alongside the
                // completing load is ignored; operands freeze at launch.
                if (bus.start && a_loaded_q && b_loaded_q) begin
                    mult_start_d = 1'b1;
                    state_d      = MULT;
                    timer_d      = '0;
                end else begin
                    if (bus.load_a) begin
                        mult_a_d   = bus.operand_in;
                        a_loaded_d = 1'b1;
                    end
                    if (bus.load_b) begin
                        mult_b_d   = bus.operand_in;
                        b_loaded_d = 1'b1;
                    end
                end
            end
            MULT: begin
                if (bus.mult_done) begin
                    sm_data_d  = bus.mult_product;
                    sm_valid_d = 1'b1;
                    state_d    = SIGN;
                    timer_d    = '0;
                end else if (timer_q == LIMIT) begin
                    state_d = ERR;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            SIGN: begin
                if (bus.sm_ready) begin
                    bcd_valid_d = 1'b1;
                    state_d     = BCD;
                    timer_d     = '0;
                end else if (timer_q == LIMIT) begin
                    state_d = ERR;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            BCD: begin
                if (bus.bcd_ready) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == LIMIT) begin
                    state_d = ERR;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ERR: begin
                if (bus.start) begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            a_loaded_q   <= 1'b0;
            b_loaded_q   <= 1'b0;
            mult_a_q     <= '0;
            mult_b_q     <= '0;
            sm_data_q    <= '0;
            mult_start_q <= 1'b0;
            sm_valid_q   <= 1'b0;
            bcd_valid_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            a_loaded_q   <= a_loaded_d;
            b_loaded_q   <= b_loaded_d;
            mult_a_q     <= mult_a_d;
            mult_b_q     <= mult_b_d;
            sm_data_q    <= sm_data_d;
            mult_start_q <= mult_start_d;
            sm_valid_q   <= sm_valid_d;
            bcd_valid_q  <= bcd_valid_d;
            done_q       <= done_d;
        end
    end

    assign bus.mult_start = mult_start_q;
    assign bus.mult_a     = mult_a_q;
    assign bus.mult_b     = mult_b_q;
    assign bus.sm_valid   = sm_valid_q;
    assign bus.sm_data    = sm_data_q;
    assign bus.bcd_valid  = bcd_valid_q;
    assign bus.done       = done_q;
    assign bus.busy       = (state_q == MULT) || (state_q == SIGN) ||
                            (state_q == BCD);
    assign bus.error      = (state_q == ERR);
    assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_mult_sequence_ctrl.sv
// Directed bench for mult_sequence_ctrl with a 4-cycle watchdog.
// Expected values are hand-computed per cycle.
module tb_mult_sequence_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mult_sequence_ctrl_if #(.OP_WIDTH(8)) bus ();

    mult_sequence_ctrl #(
        .OP_WIDTH(8),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] pulses();
        return {bus.mult_start, bus.sm_valid, bus.bcd_valid, bus.done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait n cycles with the response low, checking the controller holds.
    task automatic hold(input int n, input logic [2:0] st,
                        input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, "_quiet"}, 32'(pulses()), 32'h0);
            chk({tag, "_state"}, 32'(bus.state_dbg), 32'(st));
            chk({tag, "_busy"}, 32'(bus.busy), 32'h1);
        end
    endtask

    // One full run; d* = cycles from each pulse to its response.
    task automatic run_seq(input int dm, input int ds, input int db,
                           input logic [15:0] prod, input bit stray,
                           input string tag);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk({tag, "_ms"}, 32'(pulses()), 32'b1000);
        chk({tag, "_st1"}, 32'(bus.state_dbg), 32'd1);
        chk({tag, "_busy1"}, 32'(bus.busy), 32'h1);
        if (stray) begin
            bus.bcd_ready  = 1'b1;
            bus.load_a     = 1'b1;
            bus.operand_in = 8'h55;
        end
        hold(dm, 3'd1, {tag, "_m"});
        bus.bcd_ready    = 1'b0;
        bus.mult_done    = 1'b1;
        bus.mult_product = prod;
        tick();
        bus.mult_done    = 1'b0;
        bus.mult_product = 16'h0;
        chk({tag, "_smv"}, 32'(pulses()), 32'b0100);
        chk({tag, "_smd"}, 32'(bus.sm_data), 32'(prod));
        chk({tag, "_st2"}, 32'(bus.state_dbg), 32'd2);
        hold(ds, 3'd2, {tag, "_s"});
        bus.load_a     = 1'b0;
        bus.operand_in = 8'h0;
        bus.sm_ready   = 1'b1;
        tick();
        bus.sm_ready = 1'b0;
        chk({tag, "_bcdv"}, 32'(pulses()), 32'b0010);
        chk({tag, "_st3"}, 32'(bus.state_dbg), 32'd3);
        chk({tag, "_err3"}, 32'(bus.error), 32'h0);
        hold(db, 3'd3, {tag, "_b"});
        bus.bcd_ready = 1'b1;
        tick();
        bus.bcd_ready = 1'b0;
        chk({tag, "_done"}, 32'(pulses()), 32'b0001);
        chk({tag, "_st0"}, 32'(bus.state_dbg), 32'd0);
        chk({tag, "_busy0"}, 32'(bus.busy), 32'h0);
        chk({tag, "_smhold"}, 32'(bus.sm_data), 32'(prod));
        tick();
        chk({tag, "_post"}, 32'(pulses()), 32'h0);
        chk({tag, "_smhold2"}, 32'(bus.sm_data), 32'(prod));
    endtask

    initial begin
        bus.operand_in   = 8'h0;
        bus.load_a       = 1'b0;
        bus.load_b       = 1'b0;
        bus.start        = 1'b0;
        bus.mult_done    = 1'b0;
        bus.mult_product = 16'h0;
        bus.sm_ready     = 1'b0;
        bus.bcd_ready    = 1'b0;

        tick();
        tick();
        rst = 1'b0;
        chk("rst_pulses", 32'(pulses()), 32'h0);
        chk("rst_state", 32'(bus.state_dbg), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_err", 32'(bus.error), 32'h0);
        chk("rst_a", 32'(bus.mult_a), 32'h0);
        chk("rst_b", 32'(bus.mult_b), 32'h0);
        chk("rst_smd", 32'(bus.sm_data), 32'h0);

        bus.operand_in = 8'hFD;
        bus.load_a     = 1'b1;
        tick();
        bus.load_a     = 1'b0;
        chk("load_a", 32'(bus.mult_a), 32'hFD);
        bus.operand_in = 8'h07;
        bus.load_b     = 1'b1;
        tick();
        bus.load_b     = 1'b0;
        bus.operand_in = 8'h0;
        chk("load_b", 32'(bus.mult_b), 32'h07);
        chk("load_a_kept", 32'(bus.mult_a), 32'hFD);

        run_seq(3, 2, 2, 16'hFFEB, 1'b0, "full");

        // sm_ready on the exact limit cycle, strays in MULT and SIGN.
        run_seq(3, 3, 1, 16'hFFEB, 1'b1, "edge");
        chk("stray_a", 32'(bus.mult_a), 32'hFD);

        // Watchdog: sm_ready never comes.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("to_ms", 32'(pulses()), 32'b1000);
        tick();
        bus.mult_done    = 1'b1;
        bus.mult_product = 16'hFFEB;
        tick();
        bus.mult_done    = 1'b0;
        chk("to_smv", 32'(pulses()), 32'b0100);
        hold(3, 3'd2, "to_wait");
        tick();
        chk("to_state", 32'(bus.state_dbg), 32'd4);
        chk("to_err", 32'(bus.error), 32'h1);
        chk("to_busy", 32'(bus.busy), 32'h0);
        chk("to_pulses", 32'(pulses()), 32'h0);
        bus.sm_ready = 1'b1;
        tick();
        bus.sm_ready = 1'b0;
        chk("err_ign", 32'(bus.state_dbg), 32'd4);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("err_clr_st", 32'(bus.state_dbg), 32'd0);
        chk("err_clr", 32'(bus.error), 32'h0);
        chk("err_clr_p", 32'(pulses()), 32'h0);
        run_seq(1, 1, 1, 16'h0123, 1'b0, "retry");

        // Reset while in BCD.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.mult_done    = 1'b1;
        bus.mult_product = 16'hFFEB;
        tick();
        bus.mult_done    = 1'b0;
        tick();
        bus.sm_ready = 1'b1;
        tick();
        bus.sm_ready = 1'b0;
        chk("mr_bcd", 32'(bus.state_dbg), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_state", 32'(bus.state_dbg), 32'd0);
        chk("mr_smd", 32'(bus.sm_data), 32'h0);
        chk("mr_a", 32'(bus.mult_a), 32'h0);
        chk("mr_b", 32'(bus.mult_b), 32'h0);
        chk("mr_p", 32'(pulses()), 32'h0);
        chk("mr_busy", 32'(bus.busy), 32'h0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("mr_start_ign", 32'(pulses()), 32'h0);

        // Premature starts.
        bus.operand_in = 8'h02;
        bus.load_a     = 1'b1;
        tick();
        bus.load_a = 1'b1;
        bus.load_a = 1'b0;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("pre_a_only", 32'(pulses()), 32'h0);
        chk("pre_a_st", 32'(bus.state_dbg), 32'd0);
        bus.operand_in = 8'h03;
        bus.load_b     = 1'b1;
        bus.start      = 1'b1;
        tick();
        bus.load_b     = 1'b0;
        bus.start      = 1'b0;
        bus.operand_in = 8'h0;
        chk("pre_same", 32'(pulses()), 32'h0);
        chk("pre_same_st", 32'(bus.state_dbg), 32'd0);
        chk("pre_a", 32'(bus.mult_a), 32'h02);
        chk("pre_b", 32'(bus.mult_b), 32'h03);
        run_seq(1, 1, 1, 16'h0006, 1'b0, "late");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mult_sequence_ctrl.md
Name: mult_sequence_ctrl

Overview:
- Central controller for the multiplier display chain: operand capture, multiply, sign-magnitude conversion, binary-to-BCD conversion, display update.
- Latches two signed operands from the switch/operand bus and launches the multiplier.
- Steps each downstream stage with single-cycle valid pulses, waiting for each stage's ready before moving on.
- Per-stage watchdog moves the controller to an error state if a stage never responds.

Parameters:
- OP_WIDTH, 8, width of each signed operand.
- TIMEOUT_CYCLES, 255, maximum cycles spent waiting in any stage before error.

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- operand_in  input  OP_WIDTH  operand source value (signed, two's complement)
- load_a  input  1  single-cycle pulse: capture operand_in as A
- load_b  input  1  single-cycle pulse: capture operand_in as B
- start  input  1  single-cycle pulse: run sequence / clear error
- mult_done  input  1  multiplier result valid
- mult_product  input  2*OP_WIDTH  signed multiplier result
- sm_ready  input  1  sign_magnitude stage finished
- bcd_ready  input  1  binary_BCD stage finished
- mult_start  output  1  one-cycle pulse to multiplier
- mult_a  output  OP_WIDTH  registered operand A
- mult_b  output  OP_WIDTH  registered operand B
- sm_valid  output  1  one-cycle pulse to sign_magnitude
- sm_data  output  2*OP_WIDTH  registered product, held stable
- bcd_valid  output  1  one-cycle pulse to binary_BCD
- done  output  1  one-cycle pulse when the sequence completes
- busy  output  1  high in MULT/SIGN/BCD states
- error  output  1  high while in ERR state
- state_dbg  output  3  encoded current state

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - State IDLE.
  - All outputs 0.
  - a_loaded/b_loaded flags cleared; timer cleared.
- State encoding: IDLE=0, MULT=1, SIGN=2, BCD=3, ERR=4.
- IDLE:
  - load_a loads mult_a and sets a_loaded. load_b loads mult_b and sets b_loaded. Both in the same cycle: both load the same operand_in.
  - start with a_loaded & b_loaded both already registered: next cycle mult_start=1 for exactly one cycle, go to MULT, timer=0.
  - A start in the same cycle as the completing load is ignored.
  - start without both flags is ignored.
- MULT:
  - mult_done=1: capture mult_product into sm_data, pulse sm_valid in the next cycle, go to SIGN, timer=0.
  - sm_data and sm_valid rise on the same edge.
- SIGN: sm_ready=1 -> bcd_valid pulse next cycle, go to BCD, timer=0.
- BCD: bcd_ready=1 -> done pulse next cycle, go to IDLE.
  - a_loaded/b_loaded stay set, so a new start re-runs with the same operands.
  - sm_data holds until the next MULT capture.
- Watchdog:
  - In MULT/SIGN/BCD the timer increments every cycle the awaited ready is low.
  - When timer reaches TIMEOUT_CYCLES with ready still low -> ERR.
  - If ready is high in the same cycle the limit is reached, ready wins.
- ERR:
  - error=1, busy=0.
  - start -> IDLE with error cleared; operand flags kept.
  - All ready inputs ignored.
- Sampling rules:
  - Ready/done inputs are sampled only in their own wait state; stray pulses elsewhere are ignored.
  - Earliest response is one cycle after the corresponding valid/start pulse.
- While busy or in ERR:
  - load_a/load_b are ignored; mult_a/mult_b stay stable throughout a sequence.
  - start is ignored while busy.
- Pulse outputs are never high for more than one cycle and never overlap.
- rst asserted mid-sequence:
  - Next edge returns to IDLE, all pulses 0, flags cleared.
  - sm_data, mult_a, mult_b are cleared to 0.
- Minimum sequence latency, with each stage responding one cycle after its pulse: start -> done = 7 cycles.

Test Plan:
- Reset then operand load: rst 2 cycles -> all outputs 0, state_dbg=0. operand_in=0xFD with load_a, then 0x07 with load_b -> mult_a=0xFD, mult_b=0x07.
- Full sequence: start, model returns mult_done with product 0xFFEB (-21) after 3 cycles, sm_ready and bcd_ready each after 2 cycles:
  - mult_start, sm_valid, bcd_valid, done each appear exactly once, in that order.
  - sm_data=0xFFEB from the sm_valid cycle until the next capture.
  - busy high from the cycle after start until done.
- Premature start: start with only load_a given -> no mult_start, stays IDLE. Same-cycle load_b+start -> ignored. start one cycle later -> sequence runs.
- Timeout, TIMEOUT_CYCLES=4 in test: sm_ready held low -> ERR after 4 wait cycles, error=1. start -> IDLE, error=0. Second start runs normally with the retained operands.
- Boundary and ignore checks:
  - sm_ready arriving on the exact limit cycle -> proceeds to BCD, no error.
  - Stray bcd_ready during MULT ignored.
  - load_a during SIGN ignored, mult_a unchanged.
- Mid-operation reset: rst in BCD state -> IDLE next cycle, sm_data=0, flags cleared. A following start is ignored until both operands are reloaded.
